// File: rtl/fetch_npc_unit_if.sv
// Instruction-memory fetch bus: request/ready handshake between the PC unit and imem.
interface fetch_npc_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_npc_unit.sv
// Program counter, instruction fetch handshake and next-PC resolution for the
// multicycle MIPS datapath; holds the fetched instruction until the datapath commits it.
module fetch_npc_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_3000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    fetch_npc_unit_if.master   imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
    input  logic               commit,
    input  logic [5:0]         branch,
    input  logic [3:0]         j,
    input  logic               alu_zero,
    input  logic [31:0]        rs_val,
    output logic [31:0]        pc,
    output logic [31:0]        link_addr,
    output logic               err
);

    localparam int unsigned CNT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             state;
    logic               req;
    logic [CNT_W-1:0]   cnt;

    logic [31:0] p4;
    logic [31:0] btgt;
    logic [31:0] jtgt;
    logic [31:0] npc;
    logic        rs_gtz;
    logic        regimm_taken;
    logic        br_taken;
    logic        timeout_hit;

    // Next-PC resolution; jr/jalr beat jump/jal, which beat any taken branch.
    always_comb begin
        p4   = pc + 32'd4;
        btgt = p4 + {{14{instr[15]}}, instr[15:0], 2'b00};
        jtgt = {p4[31:28], instr[25:0], 2'b00};

        rs_gtz = !rs_val[31] && (rs_val != 32'd0);
        // bgez and bltz share an opcode; rt bit 0 (instr[16]) selects which one.
        regimm_taken = (branch[3] | branch[0]) && (instr[16] ? !rs_val[31] : rs_val[31]);
        br_taken = (branch[5] && alu_zero)
                || (branch[4] && !alu_zero)
                || (branch[2] && rs_gtz)
                || (branch[1] && !rs_gtz)
                || regimm_taken;

        npc = p4;
        if (j[1] | j[0]) begin
            npc = rs_val;
        end else if (j[3] | j[2]) begin
            npc = jtgt;
        end else if (br_taken) begin
            npc = btgt;
        end
    end

    assign timeout_hit = (IMEM_TIMEOUT != 0) && ((32'(cnt) + 32'd1) == IMEM_TIMEOUT);

    assign link_addr       = p4;
    assign imem.imem_req   = req;
    assign imem.imem_addr  = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req         <= 1'b0;
            cnt         <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // A ready seen before the request is up (just out of reset) is ignored.
                    if (!req) begin
                        req <= 1'b1;
                    end else if (imem.imem_ready) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        req         <= 1'b0;
                        cnt         <= '0;
                        state       <= EXEC;
                    end else if (timeout_hit) begin
                        err   <= 1'b1;
                        req   <= 1'b0;
                        cnt   <= '0;
                        state <= HALT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EXEC: begin
                    if (commit) begin
                        if (npc[1:0] != 2'b00) begin
                            err   <= 1'b1;
                            state <= HALT;
                        end else begin
                            pc          <= npc;
                            instr_valid <= 1'b0;
                            req         <= 1'b1;
                            state       <= FETCH;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Bench for fetch_npc_unit: directed vector table, hand-written corner sequences,
// and randomized commits checked against a next-PC reference model.
module tb_fetch_npc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int unsigned TMO    = 16;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        commit;
    logic [5:0]  branch;
    logic [3:0]  j;
    logic        alu_zero;
    logic [31:0] rs_val;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        err;

    fetch_npc_unit_if imem_bus ();

    fetch_npc_unit #(.RESET_PC(RST_PC), .IMEM_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (imem_bus),
        .instr      (instr),
        .instr_valid(instr_valid),
        .commit     (commit),
        .branch     (branch),
        .j          (j),
        .alu_zero   (alu_zero),
        .rs_val     (rs_val),
        .pc         (pc),
        .link_addr  (link_addr),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs;
    int errs;
    logic [31:0] mpc;

    typedef struct {
        logic [31:0] ins;
        logic [5:0]  br;
        logic [3:0]  jv;
        logic        az;
        logic [31:0] rs;
        logic [31:0] exp_link;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec-level next-PC: signed integer compares and plain address arithmetic.
    function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [31:0] ins,
                                            input logic [5:0] br, input logic [3:0] jv,
                                            input logic az, input logic [31:0] rs);
        int signed rsi;
        int signed off;
        bit        taken;
        rsi = $signed(rs);
        off = int'($signed(ins[15:0])) * 4;
        taken = (br[5] && az) || (br[4] && !az) || (br[2] && rsi > 0) || (br[1] && rsi <= 0)
             || ((br[3] || br[0]) && (ins[16] ? (rsi >= 0) : (rsi < 0)));
        if (jv[1] || jv[0]) return rs;
        if (jv[3] || jv[2]) return ((cur + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (taken) return cur + 32'd4 + 32'(off);
        return cur + 32'd4;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        commit = 1'b0;
        imem_bus.imem_ready = 1'b0;
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_req", 32'(imem_bus.imem_req), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mpc = RST_PC;
    endtask

    // Wait (bounded) for a request, stall dly cycles, then return word for one cycle.
    task automatic fetch_insn(input logic [31:0] word, input int dly);
        int n;
        n = 0;
        while (!imem_bus.imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", 32'(imem_bus.imem_req), 32'd1);
        check("imem_addr", imem_bus.imem_addr, mpc);
        repeat (dly) @(negedge clk);
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = word;
        @(negedge clk);
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = $urandom;
        check("instr", instr, word);
        check("instr_valid", 32'(instr_valid), 32'd1);
        check("req_drop", 32'(imem_bus.imem_req), 32'd0);
    endtask

    task automatic do_commit(input logic [5:0] br, input logic [3:0] jv, input logic az,
                             input logic [31:0] rs);
        branch   = br;
        j        = jv;
        alu_zero = az;
        rs_val   = rs;
        commit   = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        branch = '0;
        j      = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] rs;
        logic [31:0] exp;
        logic [5:0]  br;
        logic [3:0]  jv;
        logic        az;

        vecs = 0;
        errs = 0;
        rst = 1'b1;
        commit = 1'b0;
        branch = '0;
        j = '0;
        alu_zero = 1'b0;
        rs_val = '0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = '0;
        mpc = RST_PC;

        //            instr         branch     j        az    rs_val        link          pc            err
        tbl[0]  = '{32'h24080005, 6'b000000, 4'b0000, 1'b0, 32'h0,        32'h3004, 32'h3004, 1'b0};
        tbl[1]  = '{32'h1000FFFE, 6'b100000, 4'b0000, 1'b1, 32'h0,        32'h3008, 32'h3000, 1'b0};
        tbl[2]  = '{32'h1000FFFE, 6'b100000, 4'b0000, 1'b0, 32'h0,        32'h3004, 32'h3004, 1'b0};
        tbl[3]  = '{32'h1000FFFE, 6'b100000, 4'b0000, 1'b0, 32'h0,        32'h3008, 32'h3008, 1'b0};
        tbl[4]  = '{32'h04000004, 6'b001001, 4'b0000, 1'b0, 32'h80000000, 32'h300C, 32'h301C, 1'b0};
        tbl[5]  = '{32'h04010004, 6'b001001, 4'b0000, 1'b0, 32'h80000000, 32'h3020, 32'h3020, 1'b0};
        tbl[6]  = '{32'h0C000C40, 6'b000000, 4'b0100, 1'b0, 32'h0,        32'h3024, 32'h3100, 1'b0};
        tbl[7]  = '{32'h03E00008, 6'b000000, 4'b0010, 1'b0, 32'h3024,     32'h3104, 32'h3024, 1'b0};
        tbl[8]  = '{32'h1C000010, 6'b000100, 4'b0000, 1'b0, 32'h0,        32'h3028, 32'h3028, 1'b0};
        tbl[9]  = '{32'h1C000010, 6'b000100, 4'b0000, 1'b0, 32'h1,        32'h302C, 32'h306C, 1'b0};
        tbl[10] = '{32'h18000010, 6'b000010, 4'b0000, 1'b0, 32'h0,        32'h3070, 32'h30B0, 1'b0};
        tbl[11] = '{32'h1400FFF0, 6'b010000, 4'b0000, 1'b0, 32'h0,        32'h30B4, 32'h3074, 1'b0};
        tbl[12] = '{32'h0000F809, 6'b100000, 4'b0001, 1'b1, 32'h4000,     32'h3078, 32'h4000, 1'b0};
        tbl[13] = '{32'h08000400, 6'b000000, 4'b1010, 1'b0, 32'h5000,     32'h4004, 32'h5000, 1'b0};
        tbl[14] = '{32'h08000400, 6'b100000, 4'b1000, 1'b1, 32'h0,        32'h5004, 32'h1000, 1'b0};
        tbl[15] = '{32'h03E00008, 6'b000000, 4'b0010, 1'b0, 32'h1002,     32'h1004, 32'h1000, 1'b1};

        do_reset();
        @(negedge clk);
        check("req_after_rst", 32'(imem_bus.imem_req), 32'd1);

        for (int i = 0; i < 16; i++) begin
            fetch_insn(tbl[i].ins, i % 3);
            check("link_addr", link_addr, tbl[i].exp_link);
            do_commit(tbl[i].br, tbl[i].jv, tbl[i].az, tbl[i].rs);
            check("pc", pc, tbl[i].exp_pc);
            check("err", 32'(err), 32'(tbl[i].exp_err));
            if (!tbl[i].exp_err) begin
                check("valid_clr", 32'(instr_valid), 32'd0);
                mpc = tbl[i].exp_pc;
            end
        end

        // HALT after misaligned jr: frozen, commit and ready both ignored.
        repeat (3) @(negedge clk);
        check("halt_req", 32'(imem_bus.imem_req), 32'd0);
        imem_bus.imem_ready = 1'b1;
        do_commit(6'b000000, 4'b0010, 1'b0, 32'h2000);
        imem_bus.imem_ready = 1'b0;
        check("halt_pc", pc, 32'h1000);
        check("halt_err", 32'(err), 32'd1);

        // Ready already high when reset releases is not taken as a response.
        @(negedge clk);
        rst = 1'b1;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("pending_ready_valid", 32'(instr_valid), 32'd0);
        check("pending_ready_req", 32'(imem_bus.imem_req), 32'd1);
        imem_bus.imem_ready = 1'b0;
        mpc = RST_PC;

        // Wrap-around at the top of the address space.
        fetch_insn(32'h03E00008, 0);
        do_commit(6'b000000, 4'b0010, 1'b0, 32'hFFFF_FFFC);
        check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        mpc = 32'hFFFF_FFFC;
        fetch_insn(32'h0000_0000, 1);
        check("wrap_link", link_addr, 32'h0000_0000);
        do_commit(6'b000000, 4'b0000, 1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0000_0000);
        check("wrap_err", 32'(err), 32'd0);
        mpc = 32'h0;

        // Asynchronous reset between clock edges while in EXEC.
        fetch_insn(32'h2408_0001, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_pc", pc, RST_PC);
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_err", 32'(err), 32'd0);
        check("async_req", 32'(imem_bus.imem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fetch timeout: err exactly after TMO request cycles without ready.
        @(negedge clk);
        check("tmo_req", 32'(imem_bus.imem_req), 32'd1);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_early", 32'(err), 32'd0);
        @(negedge clk);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_req_drop", 32'(imem_bus.imem_req), 32'd0);
        imem_bus.imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        imem_bus.imem_ready = 1'b0;
        check("tmo_ignore_ready", 32'(instr_valid), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("tmo_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mpc = RST_PC;

        // Randomized commits against the reference model.
        for (int k = 0; k < 300; k++) begin
            w = $urandom;
            fetch_insn(w, $urandom_range(0, 4));
            case ($urandom_range(0, 7))
                1: br = 6'b100000;
                2: br = 6'b010000;
                3: br = 6'b000100;
                4: br = 6'b000010;
                5: br = 6'b001001;
                default: br = 6'b000000;
            endcase
            jv = 4'b0000;
            case ($urandom_range(0, 9))
                0: jv = 4'b1000;
                1: jv = 4'b0100;
                2: jv = 4'b0010;
                3: jv = 4'b0001;
                4: jv = 4'b1010;
                default: jv = 4'b0000;
            endcase
            az = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: rs = 32'h0;
                1: rs = 32'h1;
                2: rs = 32'hFFFF_FFFF;
                3: rs = 32'h8000_0000;
                4: rs = 32'h7FFF_FFFF;
                default: rs = $urandom;
            endcase
            if ($urandom_range(0, 7) != 0) rs[1:0] = 2'b00;
            exp = ref_npc(mpc, w, br, jv, az, rs);
            check("rnd_link", link_addr, mpc + 32'd4);
            do_commit(br, jv, az, rs);
            if (exp[1:0] != 2'b00) begin
                check("rnd_err_set", 32'(err), 32'd1);
                check("rnd_pc_hold", pc, mpc);
                do_reset();
            end else begin
                check("rnd_err", 32'(err), 32'd0);
                check("rnd_pc", pc, exp);
                mpc = exp;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
